// File: rtl/resp_checker_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : resp_checker_pkg
//  Purpose  : Shared types and constants for the response checker: the FSM
//             state encoding, the signature reset seed and the default MISR
//             feedback polynomial.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package resp_checker_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2,
      ST_ERR  = 2'd3
   } state_t;

   // Value the signature register takes on reset and at the start of a run.
   localparam int SIG_SEED = 0;

   // x^8 + x^4 + x^3 + x^2 + 1 feedback taps for an 8-bit MISR.
   localparam logic [7:0] DEFAULT_POLY = 8'h1D;

endpackage
`default_nettype wire

// File: rtl/resp_checker_if.sv
`default_nettype none
// ============================================================================
//  Module   : resp_checker_if
//  Purpose  : Handshake bundle between a stimulus source and the response
//             checker.
//  Signals  : start       - single-cycle run request
//             exp_valid   - expected vector offered
//             exp_vec     - expected vector data
//             exp_ready   - checker accepts exp_vec
//             resp_valid  - DUT response valid this cycle
//             resp_vec    - DUT response vector
//  Modports : master (stimulus side), slave (checker side)
//  Revision : 1.0  initial release
// ============================================================================
interface resp_checker_if #(
   parameter int OUT_W = 8
);
   logic             start;
   logic             exp_valid;
   logic [OUT_W-1:0] exp_vec;
   logic             exp_ready;
   logic             resp_valid;
   logic [OUT_W-1:0] resp_vec;

   modport master (
      output start, exp_valid, exp_vec, resp_valid, resp_vec,
      input  exp_ready
   );

   modport slave (
      input  start, exp_valid, exp_vec, resp_valid, resp_vec,
      output exp_ready
   );
endinterface
`default_nettype wire

// File: rtl/resp_checker_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo
//  Purpose  : Single-clock FIFO holding expected vectors. Head data is shown
//             combinationally on dout so it can be compared in the pop cycle.
//  Ports    : clk, rst_n (sync, active low), clr (sync flush),
//             push/din, pop/dout, full, empty
//  Revision : 1.0  initial release
// ============================================================================
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign dout    = mem[rd_ptr];

   // DEPTH is a power of two, so pointers wrap naturally.
   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule
`default_nettype wire

// File: rtl/resp_checker.sv
`default_nettype none
// ============================================================================
//  Module   : resp_checker
//  Purpose  : Compares a stream of DUT responses against buffered expected
//             vectors, counts mismatches, records the first failing index
//             and compacts all responses into a MISR signature.
//  Ports    : clk, rst_n (sync, active low)
//             bus            - resp_checker_if.slave handshake bundle
//             busy/done/pass/underflow_err - run status
//             mismatch_cnt, first_fail_idx, signature - run results
//  Revision : 1.0  initial release
// ============================================================================
module resp_checker
   import resp_checker_pkg::*;
#(
   parameter int               OUT_W      = 8,
   parameter int               VEC_LEN    = 16,
   parameter int               FIFO_DEPTH = 4,
   parameter logic [OUT_W-1:0] POLY       = OUT_W'(DEFAULT_POLY),
   localparam int              CNT_W      = $clog2(VEC_LEN + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   resp_checker_if.slave    bus,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic             underflow_err,
   output logic [CNT_W-1:0] mismatch_cnt,
   output logic [CNT_W-1:0] first_fail_idx,
   output logic [OUT_W-1:0] signature
);
   state_t           state;
   state_t           state_nxt;
   logic             run_clr;
   logic             push_en;
   logic             pop_en;
   logic             ready;
   logic             fifo_full;
   logic             fifo_empty;
   logic [OUT_W-1:0] fifo_head;
   logic [CNT_W-1:0] vec_idx;
   logic [OUT_W-1:0] sig_nxt;

   // Status outputs are gated by rst_n so they read 0 for the whole time
   // reset is held, not only after the reset edge.
   assign ready         = rst_n && (state == ST_RUN) && !fifo_full;
   assign bus.exp_ready = ready;
   assign busy          = rst_n && (state == ST_RUN);
   assign done          = rst_n && (state == ST_DONE);
   assign underflow_err = rst_n && (state == ST_ERR);
   assign pass          = done && (mismatch_cnt == '0);

   sync_fifo #(
      .WIDTH (OUT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_exp_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (run_clr),
      .push  (push_en),
      .din   (bus.exp_vec),
      .pop   (pop_en),
      .dout  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      run_clr   = 1'b0;
      push_en   = 1'b0;
      pop_en    = 1'b0;
      case (state)
         ST_RUN: begin
            push_en = bus.exp_valid && ready;
            if (bus.resp_valid) begin
               if (fifo_empty) begin
                  // No bypass: a response with nothing buffered is an
                  // underflow and any same-cycle push is dropped.
                  state_nxt = ST_ERR;
                  push_en   = 1'b0;
               end else begin
                  pop_en = 1'b1;
                  if (vec_idx == CNT_W'(VEC_LEN - 1)) state_nxt = ST_DONE;
               end
            end
         end
         default: begin
            if (bus.start) begin
               state_nxt = ST_RUN;
               run_clr   = 1'b1;
            end
         end
      endcase
   end

   // MISR step: shift left, fold in POLY when the bit shifted out was set,
   // then mix in the response.
   assign sig_nxt = {signature[OUT_W-2:0], 1'b0}
                  ^ (signature[OUT_W-1] ? POLY : '0)
                  ^ bus.resp_vec;

   always_ff @(posedge clk) begin
      if (!rst_n || run_clr) begin
         vec_idx        <= '0;
         mismatch_cnt   <= '0;
         first_fail_idx <= '1;
         signature      <= OUT_W'(SIG_SEED);
      end else if (pop_en) begin
         vec_idx   <= vec_idx + CNT_W'(1);
         signature <= sig_nxt;
         if (fifo_head != bus.resp_vec) begin
            if (mismatch_cnt != CNT_W'(VEC_LEN))
               mismatch_cnt <= mismatch_cnt + CNT_W'(1);
            if (first_fail_idx == '1)
               first_fail_idx <= vec_idx;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_resp_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_resp_checker
//  Purpose  : Self-checking bench for resp_checker. Directed runs push their
//             hand-computed end-of-run results into a scoreboard queue; a
//             monitor pops and compares whenever done or underflow_err rises.
//  Revision : 1.0  initial release
// ============================================================================
module tb_resp_checker;
   localparam int         OUT_W   = 8;
   localparam int         VEC_LEN = 4;
   localparam int         DEPTH   = 4;
   localparam int         CNT_W   = $clog2(VEC_LEN + 1);
   localparam logic [7:0] POLY    = 8'h1D;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             busy, done, pass, underflow_err;
   logic [CNT_W-1:0] mismatch_cnt, first_fail_idx;
   logic [OUT_W-1:0] signature;

   always #5 clk = ~clk;

   resp_checker_if #(.OUT_W(OUT_W)) bus ();

   resp_checker #(
      .OUT_W      (OUT_W),
      .VEC_LEN    (VEC_LEN),
      .FIFO_DEPTH (DEPTH),
      .POLY       (POLY)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .bus            (bus),
      .busy           (busy),
      .done           (done),
      .pass           (pass),
      .underflow_err  (underflow_err),
      .mismatch_cnt   (mismatch_cnt),
      .first_fail_idx (first_fail_idx),
      .signature      (signature)
   );

   typedef struct {
      string            nm;
      logic             uf;
      logic             ps;
      logic [CNT_W-1:0] mcnt;
      logic [CNT_W-1:0] ffi;
      logic [OUT_W-1:0] sig;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   vectors = 0;
   int   miscompares = 0;
   logic prev_done = 1'b0;
   logic prev_uf = 1'b0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0h, required %0h", nm, act, req);
      end
   endtask

   task automatic expect_result(input string nm, input logic uf, input logic ps,
                                input logic [CNT_W-1:0] mcnt, input logic [CNT_W-1:0] ffi,
                                input logic [OUT_W-1:0] sig);
      exp_t e;
      e.nm = nm; e.uf = uf; e.ps = ps; e.mcnt = mcnt; e.ffi = ffi; e.sig = sig;
      sb_q.push_back(e);
   endtask

   // Monitor: a rising done or underflow_err is a presented result.
   always @(negedge clk) begin
      if ((done && !prev_done) || (underflow_err && !prev_uf)) begin
         if (sb_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_result: done=%0b uf=%0b with no expectation queued",
                     done, underflow_err);
         end else begin
            mon_e = sb_q.pop_front();
            check({mon_e.nm, "_done"},      done,           !mon_e.uf);
            check({mon_e.nm, "_underflow"}, underflow_err,  mon_e.uf);
            check({mon_e.nm, "_pass"},      pass,           mon_e.ps);
            check({mon_e.nm, "_mcnt"},      mismatch_cnt,   mon_e.mcnt);
            check({mon_e.nm, "_ffi"},       first_fail_idx, mon_e.ffi);
            check({mon_e.nm, "_sig"},       signature,      mon_e.sig);
         end
      end
      prev_done = done;
      prev_uf   = underflow_err;
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_bus();
      bus.start      = 1'b0;
      bus.exp_valid  = 1'b0;
      bus.exp_vec    = '0;
      bus.resp_valid = 1'b0;
      bus.resp_vec   = '0;
   endtask

   task automatic do_start();
      bus.start = 1'b1;
      cyc();
      bus.start = 1'b0;
   endtask

   task automatic push_exp(input logic [OUT_W-1:0] v);
      bus.exp_valid = 1'b1;
      bus.exp_vec   = v;
      check("push_ready", bus.exp_ready, 1);
      cyc();
      bus.exp_valid = 1'b0;
   endtask

   task automatic give_resp(input logic [OUT_W-1:0] v);
      bus.resp_valid = 1'b1;
      bus.resp_vec   = v;
      cyc();
      bus.resp_valid = 1'b0;
   endtask

   task automatic run_bulk(input logic [OUT_W-1:0] ev [4], input logic [OUT_W-1:0] rv [4]);
      for (int i = 0; i < 4; i++) push_exp(ev[i]);
      for (int i = 0; i < 4; i++) give_resp(rv[i]);
   endtask

   // One push ahead, then push k while answering k-1.
   task automatic run_interleaved(input logic [OUT_W-1:0] ev [4], input logic [OUT_W-1:0] rv [4]);
      bus.exp_valid = 1'b1;
      bus.exp_vec   = ev[0];
      check("il_ready0", bus.exp_ready, 1);
      cyc();
      for (int k = 1; k < 4; k++) begin
         bus.exp_vec    = ev[k];
         bus.resp_valid = 1'b1;
         bus.resp_vec   = rv[k-1];
         check("il_ready", bus.exp_ready, 1);
         cyc();
      end
      bus.exp_valid = 1'b0;
      bus.resp_vec  = rv[3];
      cyc();
      idle_bus();
   endtask

   task automatic wait_end(input string nm);
      int n = 0;
      while (!done && !underflow_err && n < 20) begin
         cyc();
         n++;
      end
      check({nm, "_timeout"}, (n < 20), 1);
      cyc();
   endtask

   logic [OUT_W-1:0] ev [4];
   logic [OUT_W-1:0] rv [4];

   initial begin
      idle_bus();
      rst_n = 1'b0;
      repeat (2) cyc();
      check("rst_busy",  busy, 0);
      check("rst_done",  done, 0);
      check("rst_pass",  pass, 0);
      check("rst_uf",    underflow_err, 0);
      check("rst_ready", bus.exp_ready, 0);
      rst_n = 1'b1;
      cyc();
      check("rst_mcnt", mismatch_cnt, 0);
      check("rst_ffi",  first_fail_idx, 3'b111);
      check("rst_sig",  signature, 8'h00);

      // Clean run, interleaved: 01,02,80,00 -> signature 1D.
      ev = '{8'h01, 8'h02, 8'h80, 8'h00};
      rv = '{8'h01, 8'h02, 8'h80, 8'h00};
      expect_result("clean", 1'b0, 1'b1, 3'd0, 3'b111, 8'h1D);
      do_start();
      check("start_busy", busy, 1);
      run_interleaved(ev, rv);
      wait_end("clean");

      // Mismatch at index 2 (81): signature 01,00,81,1F.
      rv[2] = 8'h81;
      expect_result("mis_idx2", 1'b0, 1'b0, 3'd1, 3'd2, 8'h1F);
      do_start();
      run_bulk(ev, rv);
      wait_end("mis_idx2");

      // Response in the first RUN cycle with an empty FIFO, push dropped.
      expect_result("underflow", 1'b1, 1'b0, 3'd0, 3'b111, 8'h00);
      do_start();
      bus.resp_valid = 1'b1;
      bus.resp_vec   = 8'h01;
      bus.exp_valid  = 1'b1;
      bus.exp_vec    = 8'h55;
      cyc();
      idle_bus();
      check("uf_next_cycle", underflow_err, 1);
      bus.resp_valid = 1'b1;
      bus.resp_vec   = 8'hFF;
      cyc();
      idle_bus();
      check("err_hold_sig", signature, 8'h00);
      check("err_hold_uf",  underflow_err, 1);
      do_start();
      check("restart_busy",  busy, 1);
      check("restart_uf",    underflow_err, 0);
      check("restart_ready", bus.exp_ready, 1);

      // Fill the FIFO, then push+pop while full; order 11,22,33,44 -> sig 22.
      expect_result("order", 1'b0, 1'b1, 3'd0, 3'b111, 8'h22);
      push_exp(8'h11);
      push_exp(8'h22);
      push_exp(8'h33);
      push_exp(8'h44);
      check("full_ready", bus.exp_ready, 0);
      bus.exp_valid  = 1'b1;
      bus.exp_vec    = 8'hEE;
      bus.resp_valid = 1'b1;
      bus.resp_vec   = 8'h11;
      check("full_pushpop_ready", bus.exp_ready, 0);
      cyc();
      idle_bus();
      check("after_pop_ready", bus.exp_ready, 1);
      give_resp(8'h22);
      give_resp(8'h33);
      give_resp(8'h44);
      wait_end("order");

      // Results hold in DONE while inputs wiggle.
      bus.resp_valid = 1'b1;
      bus.resp_vec   = 8'hFF;
      bus.exp_valid  = 1'b1;
      bus.exp_vec    = 8'hFF;
      cyc();
      cyc();
      idle_bus();
      check("hold_sig",   signature, 8'h22);
      check("hold_done",  done, 1);
      check("hold_ready", bus.exp_ready, 0);
      check("hold_mcnt",  mismatch_cnt, 0);

      // Reset after 2 of 4 vectors.
      rv = '{8'h01, 8'h02, 8'h80, 8'h00};
      do_start();
      for (int i = 0; i < 4; i++) push_exp(ev[i]);
      give_resp(rv[0]);
      give_resp(rv[1]);
      rst_n = 1'b0;
      #1;
      check("inrst_busy",  busy, 0);
      check("inrst_ready", bus.exp_ready, 0);
      check("inrst_done",  done, 0);
      cyc();
      rst_n = 1'b1;
      check("midrst_mcnt", mismatch_cnt, 0);
      check("midrst_ffi",  first_fail_idx, 3'b111);
      check("midrst_sig",  signature, 8'h00);
      check("midrst_busy", busy, 0);
      check("midrst_uf",   underflow_err, 0);
      cyc();
      cyc();
      check("no_partial_done", done, 0);

      expect_result("post_reset", 1'b0, 1'b1, 3'd0, 3'b111, 8'h1D);
      do_start();
      run_bulk(ev, rv);
      wait_end("post_reset");

      repeat (3) cyc();
      check("scoreboard_drain", sb_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
